obstacle_pillars: RTL and testbench
===================================

# obstacle_pillars

Parametrised moving-pillar obstacle generator for the game screen: draws up to `NUM_PILLARS` vertical pillars that scroll leftward once per frame, respawn at the right edge with alternating heights, and report the hit pixel coordinates to the collision checker. Sits in the VGA timing chain between the background/menu stage and the collision/mouse stages. It passes all timing signals through with one cycle of delay.

## Interface
Parameters:
- `NUM_PILLARS`, 2: number of pillars, legal 1..4.
- `PILLAR_W`, 20: pillar width in pixels.
- `PILLAR_H`, 200: pillar height in pixels.
- `SPAWN_X`, 662: left edge at spawn and respawn.
- `LEFT_LIMIT`, 341: respawn threshold on the left edge.
- `SPACING`, 160: initial horizontal offset between consecutive pillars.
- `TOP_A`, 417: pillar top while its flip bit is 0.
- `TOP_B`, 317: pillar top while its flip bit is 1.
- `SPEED`, 1: pixels moved per move step.
- `MAX_SPEED`, 4: speed cap, used only with `OBSTACLE_SPEEDUP_EN`.
- `FRAMES_PER_MOVE`, 1: frame ticks per move step, ≥1.
- `COLOR`, 12'hfff: pillar RGB.

Ports:
- `pclk` in 1: pixel clock. Only clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in 12: pixel counters.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1: timing signals.
- `rgb_in` in 12: upstream pixel colour.
- `game_on`, `play_selected`, `menu_on` in 1: game-state controls.
- `hcount_out`, `vcount_out` out 12: counters, delayed one cycle.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1: timing, delayed one cycle.
- `rgb_out` out 12: output pixel colour.
- `obstacle_x`, `obstacle_y` out 12: hit pixel coordinates; 0 when no hit.
- `obstacle_hit` out 1: current pixel lies inside a pillar.

## Operation
- Per-pillar state:
  - `left[i]` (12 b), reset value `SPAWN_X − i·SPACING`.
  - `flip[i]`, reset value 0.
  - Top edge `top[i]` = `flip[i]` ? `TOP_B` : `TOP_A`.
- Inside test for pillar i: `left ≤ hcount < left+PILLAR_W` and `top ≤ vcount < top+PILLAR_H`. Unsigned 12-bit compare; sums computed at 13 bits.
- On a hit to any pillar:
  - `rgb_out` = `COLOR`.
  - `obstacle_x`/`obstacle_y` = the incoming counters.
  - `obstacle_hit` = 1.
  - Otherwise `rgb_out` = `rgb_in` and the other three outputs are 0.
- Overlapping pillars give an identical result; no priority is needed.
- Frame tick: rising edge of `vsync_in`, detected against a registered copy of `vsync_in`.
- FSM:
  - IDLE: nothing drawn; pillars held at reset values; frame counter = 0. Go to RUN when (`game_on` | `play_selected`) & !`menu_on`.
  - RUN: draw pillars. On each tick, increment the frame counter. When it reaches `FRAMES_PER_MOVE`−1, clear it and do a move step. Go to IDLE when `menu_on` | !`play_selected`.
- Move step, applied to each pillar independently:
  - If `left ≤ LEFT_LIMIT`: `left` ← `SPAWN_X` and `flip` toggles.
  - Else: `left` ← `left − speed`.
- Entering IDLE from RUN reloads all pillar registers with their reset values.

## Timing
- Every output is registered and has exactly 1 cycle of latency from the inputs.
- Reset clears all outputs to 0, state to IDLE, frame counter to 0, `speed` to `SPEED`, and pillars to their reset values.
- A position update takes effect for pixels sampled on the cycle after the tick. Ticks fall in vertical blanking, so no frame tears.
- Tick and exit condition in the same cycle: exit wins; positions reload and there is no move.
- IDLE→RUN and the first drawn pixel: drawing starts in the cycle after the state register becomes RUN.
- `rst` mid-frame takes priority over everything else.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined:
  - Each respawn of pillar 0 sets `speed` ← min(`speed`+1, `MAX_SPEED`).
  - `speed` returns to `SPEED` on reset or on entering IDLE.
- Not defined: `speed` is the constant `SPEED` and `MAX_SPEED` is ignored.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then `play_selected`=1. Pixel (670,500) → one cycle later `rgb_out`=fff, `obstacle_x`=670, `obstacle_y`=500, `obstacle_hit`=1. Pixel (682,500) → `rgb_out`=`rgb_in`, coordinates 0, `obstacle_hit`=0.
- Pixel (510,416) → miss, because it is above `TOP_A`=417. Pixel (510,417) → hit on pillar 1, whose left edge is 502.
- One vsync rising edge → pillar 0 left edge = 661. Pixel (681,500) now misses and (661,500) hits.
- 160 ticks bring pillar 1 to left edge 342; tick 161 → 341; tick 162 → respawn at 662, top 317. Pixel (670,317) hits and (670,316) misses.
- `menu_on` pulse during RUN on the same cycle as a tick → IDLE, no drawing. On restart, pillar 0 is at 662 and pillar 1 at 502.
- `FRAMES_PER_MOVE`=3: pillar 0 moves 662→661 only on the 3rd tick.
- With `OBSTACLE_SPEEDUP_EN`: after pillar 0's first respawn, consecutive left edges are 662→660→658.

Source files
------------

// File: rtl/obstacle_pillars_if.sv
// Video-stream bundle for obstacle_pillars: upstream timing/pixel in, game
// controls in, delayed timing plus pillar colour and hit coordinates out.
interface obstacle_pillars_if;
  logic [11:0] hcount_in;
  logic [11:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic        game_on;
  logic        play_selected;
  logic        menu_on;

  logic [11:0] hcount_out;
  logic [11:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [11:0] obstacle_x;
  logic [11:0] obstacle_y;
  logic        obstacle_hit;

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
           game_on, play_selected, menu_on,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, obstacle_x, obstacle_y, obstacle_hit
  );

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
           game_on, play_selected, menu_on,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, obstacle_x, obstacle_y, obstacle_hit
  );
endinterface

// File: rtl/obstacle_pillars.sv
// Scrolling pillar obstacles overlaid on the VGA stream, one cycle of latency.
// Optional feature macro: OBSTACLE_SPEEDUP_EN (pillar-0 respawns raise speed).

module obstacle_pillars_lane #(
  parameter int IDX        = 0,
  parameter int PILLAR_W   = 20,
  parameter int PILLAR_H   = 200,
  parameter int SPAWN_X    = 662,
  parameter int LEFT_LIMIT = 341,
  parameter int SPACING    = 160,
  parameter int TOP_A      = 417,
  parameter int TOP_B      = 317
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        reload,
  input  logic        move,
  input  logic [11:0] speed,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic        hit,
  output logic        respawn
);
  localparam logic [11:0] INIT_LEFT = 12'(SPAWN_X - IDX * SPACING);

  logic [11:0] left_q, left_d;
  logic        flip_q, flip_d;
  logic [11:0] top;
  logic        wrap;
  logic        in_x, in_y;

  assign wrap = (left_q <= 12'(LEFT_LIMIT));
  assign top  = flip_q ? 12'(TOP_B) : 12'(TOP_A);

  always_comb begin
    left_d  = left_q;
    flip_d  = flip_q;
    respawn = 1'b0;
    if (reload) begin
      left_d = INIT_LEFT;
      flip_d = 1'b0;
    end else if (move) begin
      if (wrap) begin
        left_d  = 12'(SPAWN_X);
        flip_d  = ~flip_q;
        respawn = 1'b1;
      end else begin
        left_d = left_q - speed;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      left_q <= INIT_LEFT;
      flip_q <= 1'b0;
    end else begin
      left_q <= left_d;
      flip_q <= flip_d;
    end
  end

  // 13-bit upper bounds so a pillar near 4095 cannot wrap its right/bottom edge
  assign in_x = ({1'b0, hcount} >= {1'b0, left_q}) &&
                ({1'b0, hcount} <  ({1'b0, left_q} + 13'(PILLAR_W)));
  assign in_y = ({1'b0, vcount} >= {1'b0, top}) &&
                ({1'b0, vcount} <  ({1'b0, top} + 13'(PILLAR_H)));
  assign hit  = in_x && in_y;
endmodule

module obstacle_pillars #(
  parameter int          NUM_PILLARS     = 2,
  parameter int          PILLAR_W        = 20,
  parameter int          PILLAR_H        = 200,
  parameter int          SPAWN_X         = 662,
  parameter int          LEFT_LIMIT      = 341,
  parameter int          SPACING         = 160,
  parameter int          TOP_A           = 417,
  parameter int          TOP_B           = 317,
  parameter int          SPEED           = 1,
  parameter int          MAX_SPEED       = 4,
  parameter int          FRAMES_PER_MOVE = 1,
  parameter logic [11:0] COLOR           = 12'hfff
) (
  input logic                 pclk,
  input logic                 rst,
  obstacle_pillars_if.slave   bus
);
  localparam int FC_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic [11:0] ox;
    logic [11:0] oy;
    logic        hit;
  } out_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             vsync_q, vsync_d;
  out_t             out_q, out_d;
  logic             tick, start, stop, move, reload, draw, any_hit;
  logic [11:0]      speed;
  logic [NUM_PILLARS-1:0] lane_hit;
  logic [NUM_PILLARS-1:0] lane_respawn;

  assign vsync_d = bus.vsync_in;
  assign tick    = bus.vsync_in & ~vsync_q;
  assign start   = (bus.game_on | bus.play_selected) & ~bus.menu_on;
  assign stop    = bus.menu_on | ~bus.play_selected;
  assign draw    = (state_q == S_RUN);

  // Exit beats a same-cycle tick: the RUN branch checks stop before tick.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    move    = 1'b0;
    reload  = 1'b0;
    case (state_q)
      S_IDLE: begin
        reload = 1'b1;
        fc_d   = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          reload  = 1'b1;
          fc_d    = '0;
        end else if (tick) begin
          if (fc_q == FC_W'(FRAMES_PER_MOVE - 1)) begin
            fc_d = '0;
            move = 1'b1;
          end else begin
            fc_d = fc_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_PILLARS; i++) begin : g_lane
    obstacle_pillars_lane #(
      .IDX(i), .PILLAR_W(PILLAR_W), .PILLAR_H(PILLAR_H), .SPAWN_X(SPAWN_X),
      .LEFT_LIMIT(LEFT_LIMIT), .SPACING(SPACING), .TOP_A(TOP_A), .TOP_B(TOP_B)
    ) u_lane (
      .pclk(pclk), .rst(rst), .reload(reload), .move(move), .speed(speed),
      .hcount(bus.hcount_in), .vcount(bus.vcount_in),
      .hit(lane_hit[i]), .respawn(lane_respawn[i])
    );
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [11:0] speed_q, speed_d;
  logic        unused_respawn;

  always_comb begin
    speed_d = speed_q;
    if (reload)
      speed_d = 12'(SPEED);
    else if (lane_respawn[0])
      speed_d = (speed_q >= 12'(MAX_SPEED)) ? 12'(MAX_SPEED) : speed_q + 12'd1;
  end

  always_ff @(posedge pclk) begin
    if (rst) speed_q <= 12'(SPEED);
    else     speed_q <= speed_d;
  end

  assign speed          = speed_q;
  assign unused_respawn = ^lane_respawn;
`else
  logic unused_cfg;
  assign speed      = 12'(SPEED);
  assign unused_cfg = ^{lane_respawn, 12'(MAX_SPEED)};
`endif

  assign any_hit = draw & (|lane_hit);

  always_comb begin
    out_d        = '0;
    out_d.hcount = bus.hcount_in;
    out_d.vcount = bus.vcount_in;
    out_d.hsync  = bus.hsync_in;
    out_d.vsync  = bus.vsync_in;
    out_d.hblnk  = bus.hblnk_in;
    out_d.vblnk  = bus.vblnk_in;
    out_d.rgb    = bus.rgb_in;
    if (any_hit) begin
      out_d.rgb = COLOR;
      out_d.ox  = bus.hcount_in;
      out_d.oy  = bus.vcount_in;
      out_d.hit = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      vsync_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      vsync_q <= vsync_d;
      out_q   <= out_d;
    end
  end

  assign bus.hcount_out   = out_q.hcount;
  assign bus.vcount_out   = out_q.vcount;
  assign bus.hsync_out    = out_q.hsync;
  assign bus.vsync_out    = out_q.vsync;
  assign bus.hblnk_out    = out_q.hblnk;
  assign bus.vblnk_out    = out_q.vblnk;
  assign bus.rgb_out      = out_q.rgb;
  assign bus.obstacle_x   = out_q.ox;
  assign bus.obstacle_y   = out_q.oy;
  assign bus.obstacle_hit = out_q.hit;
endmodule

// File: tb/tb_obstacle_pillars.sv
// Self-checking bench for obstacle_pillars: directed scenarios plus random
// pixels/ticks checked against a position-list model of the pillars.
module tb_obstacle_pillars;
  localparam int NP = 2;
`ifdef OBSTACLE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  obstacle_pillars_if bus ();
  obstacle_pillars_if bus3 ();

  obstacle_pillars u_dut (.pclk(pclk), .rst(rst), .bus(bus));
  obstacle_pillars #(.FRAMES_PER_MOVE(3)) u_dut3 (.pclk(pclk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Reference: pillar positions as plain integers, moved frame by frame.
  int m_left [NP];
  bit m_flip [NP];
  int m_speed;
  int m_frames;
  bit m_run;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      m_left[i] = 662 - i * 160;
      m_flip[i] = 1'b0;
    end
    m_speed  = 1;
    m_frames = 0;
  endfunction

  function automatic void model_tick();
    int sp;
    if (!m_run) return;
    m_frames++;
    if (m_frames < 1) return;
    m_frames = 0;
    sp = m_speed;
    for (int i = 0; i < NP; i++) begin
      if (m_left[i] <= 341) begin
        m_left[i] = 662;
        m_flip[i] = !m_flip[i];
        if (i == 0 && SPEEDUP) m_speed = (m_speed + 1 > 4) ? 4 : m_speed + 1;
      end else begin
        m_left[i] = m_left[i] - sp;
      end
    end
  endfunction

  function automatic logic [36:0] model_pixel(input int h, input int v, input logic [11:0] rgb);
    bit hit = 1'b0;
    for (int i = 0; i < NP; i++) begin
      int top = m_flip[i] ? 317 : 417;
      if (h >= m_left[i] && h < m_left[i] + 20 && v >= top && v < top + 200) hit = 1'b1;
    end
    if (m_run && hit) return {12'hfff, 12'(h), 12'(v), 1'b1};
    return {rgb, 24'd0, 1'b0};
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_pixel(input int h, input int v, input logic [11:0] rgb, output logic [36:0] obs);
    bus.hcount_in = 12'(h);
    bus.vcount_in = 12'(v);
    bus.rgb_in    = rgb;
    step();
    obs = {bus.rgb_out, bus.obstacle_x, bus.obstacle_y, bus.obstacle_hit};
  endtask

  task automatic do_tick();
    bus.vsync_in = 1'b1;
    step();
    bus.vsync_in = 1'b0;
    step();
    model_tick();
  endtask

  task automatic test_reset();
    logic [36:0] obs, exp;
    rst = 1'b1;
    bus.hcount_in = 12'd670; bus.vcount_in = 12'd500; bus.rgb_in = 12'h5a5;
    bus.hsync_in = 1'b1; bus.hblnk_in = 1'b1; bus.vblnk_in = 1'b1;
    step(); step();
    total++;
    if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out,
         bus.vblnk_out, bus.rgb_out, bus.obstacle_x, bus.obstacle_y, bus.obstacle_hit} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got h=%0d v=%0d rgb=%h hit=%b, need all zero",
               bus.hcount_out, bus.vcount_out, bus.rgb_out, bus.obstacle_hit);
    end
    rst = 1'b0;
    bus.hsync_in = 1'b0; bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
    model_reset();
    m_run = 1'b0;
    // idle: pillar 0 sits at 662 but must not be drawn
    apply_pixel(670, 500, 12'h123, obs);
    exp = model_pixel(670, 500, 12'h123);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL idle_no_draw: got %h need %h", obs, exp); end
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] t = 4'($urandom);
      logic [11:0] h = 12'($urandom), v = 12'($urandom);
      bus.hsync_in = t[0]; bus.vsync_in = t[1]; bus.hblnk_in = t[2]; bus.vblnk_in = t[3];
      bus.hcount_in = h; bus.vcount_in = v;
      step();
      total++;
      if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out}
          !== {h, v, t[0], t[1], t[2], t[3]}) begin
        bad++;
        $display("FAIL passthrough: got h=%0d v=%0d sync=%b%b%b%b need h=%0d v=%0d sync=%b%b%b%b",
                 bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out,
                 bus.vblnk_out, h, v, t[0], t[1], t[2], t[3]);
      end
    end
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
    step();
  endtask

  task automatic test_basic_hit();
    logic [36:0] obs;
    bus.play_selected = 1'b1;
    step(); step();
    m_run = 1'b1;
    apply_pixel(670, 500, 12'h0a0, obs);
    total++;
    if (obs !== {12'hfff, 12'd670, 12'd500, 1'b1}) begin bad++; $display("FAIL hit_670_500: got %h", obs); end
    apply_pixel(682, 500, 12'h0a0, obs);
    total++;
    if (obs !== {12'h0a0, 24'd0, 1'b0}) begin bad++; $display("FAIL miss_682_500: got %h", obs); end
    apply_pixel(510, 416, 12'h00b, obs);
    total++;
    if (obs !== {12'h00b, 24'd0, 1'b0}) begin bad++; $display("FAIL miss_510_416: got %h", obs); end
    apply_pixel(510, 417, 12'h00b, obs);
    total++;
    if (obs !== {12'hfff, 12'd510, 12'd417, 1'b1}) begin bad++; $display("FAIL hit_510_417: got %h", obs); end
  endtask

  task automatic test_tick();
    logic [36:0] obs;
    do_tick();
    apply_pixel(681, 500, 12'h321, obs);
    total++;
    if (obs !== {12'h321, 24'd0, 1'b0}) begin bad++; $display("FAIL tick_miss_681: got %h", obs); end
    apply_pixel(661, 500, 12'h321, obs);
    total++;
    if (obs !== {12'hfff, 12'd661, 12'd500, 1'b1}) begin bad++; $display("FAIL tick_hit_661: got %h", obs); end
  endtask

  task automatic test_respawn();
    logic [36:0] obs;
    for (int t = 0; t < 159; t++) do_tick();
    apply_pixel(342, 500, 12'h111, obs);   // 160 ticks: pillar 1 at 342
    total++;
    if (obs !== {12'hfff, 12'd342, 12'd500, 1'b1}) begin bad++; $display("FAIL pillar1_at_342: got %h", obs); end
    do_tick();
    apply_pixel(341, 500, 12'h111, obs);
    total++;
    if (obs !== {12'hfff, 12'd341, 12'd500, 1'b1}) begin bad++; $display("FAIL pillar1_at_341: got %h", obs); end
    do_tick();
    apply_pixel(670, 317, 12'h222, obs);
    total++;
    if (obs !== {12'hfff, 12'd670, 12'd317, 1'b1}) begin bad++; $display("FAIL respawn_hit_317: got %h", obs); end
    apply_pixel(670, 316, 12'h222, obs);
    total++;
    if (obs !== {12'h222, 24'd0, 1'b0}) begin bad++; $display("FAIL respawn_miss_316: got %h", obs); end
  endtask

  task automatic test_menu_exit();
    logic [36:0] obs;
    int hs [4] = '{662, 661, 502, 501};
    bit he [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.menu_on  = 1'b1;
    bus.vsync_in = 1'b1;
    step();
    bus.vsync_in = 1'b0;
    model_reset();
    m_run = 1'b0;
    apply_pixel(670, 500, 12'h444, obs);
    total++;
    if (obs !== {12'h444, 24'd0, 1'b0}) begin bad++; $display("FAIL menu_no_draw: got %h", obs); end
    bus.menu_on = 1'b0;
    step();
    m_run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_pixel(hs[k], 500, 12'h555, obs);
      total++;
      if (obs[0] !== he[k]) begin bad++; $display("FAIL restart_x%0d: got hit=%b need %b", hs[k], obs[0], he[k]); end
    end
  endtask

  task automatic test_random();
    logic [36:0] obs, exp;
    for (int n = 0; n < 400; n++) begin
      int r = int'($urandom_range(0, 19));
      if (r < 8) begin
        do_tick();
      end else if (r == 8) begin
        bus.play_selected = 1'b0;
        step();
        model_reset();
        bus.play_selected = 1'b1;
        step();
      end else begin
        int h = int'($urandom_range(300, 700));
        int v = int'($urandom_range(300, 640));
        logic [11:0] c = 12'($urandom);
        apply_pixel(h, v, c, obs);
        exp = model_pixel(h, v, c);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL random_px(%0d,%0d): got %h need %h", h, v, obs, exp); end
      end
    end
  endtask

  task automatic test_frames_per_move();
    bus3.play_selected = 1'b1;
    step(); step();
    for (int t = 1; t <= 3; t++) begin
      bus3.vsync_in = 1'b1; step();
      bus3.vsync_in = 1'b0; step();
      bus3.hcount_in = 12'd661; bus3.vcount_in = 12'd500;
      step();
      total++;
      if (bus3.obstacle_hit !== (t == 3)) begin
        bad++; $display("FAIL fpm3_tick%0d_x661: got hit=%b need %b", t, bus3.obstacle_hit, t == 3);
      end
      bus3.hcount_in = 12'd681;
      step();
      total++;
      if (bus3.obstacle_hit !== (t != 3)) begin
        bad++; $display("FAIL fpm3_tick%0d_x681: got hit=%b need %b", t, bus3.obstacle_hit, t != 3);
      end
    end
  endtask

`ifdef OBSTACLE_SPEEDUP_EN
  task automatic test_speedup();
    logic [36:0] obs;
    int edges [3] = '{662, 660, 658};
    bus.play_selected = 1'b0; step();
    bus.play_selected = 1'b1; step();
    model_reset();
    for (int t = 0; t < 322; t++) do_tick();  // tick 322 respawns pillar 0
    for (int k = 0; k < 3; k++) begin
      if (k > 0) do_tick();
      apply_pixel(edges[k], 400, 12'h777, obs);
      total++;
      if (obs[0] !== 1'b1) begin bad++; $display("FAIL speedup_hit_%0d: got hit=%b need 1", edges[k], obs[0]); end
      apply_pixel(edges[k] - 1, 400, 12'h777, obs);
      total++;
      if (obs[0] !== 1'b0) begin bad++; $display("FAIL speedup_miss_%0d: got hit=%b need 0", edges[k] - 1, obs[0]); end
    end
  endtask
`endif

  initial begin
    bus.hcount_in = '0; bus.vcount_in = '0; bus.rgb_in = '0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
    bus.game_on = 1'b0; bus.play_selected = 1'b0; bus.menu_on = 1'b0;
    bus3.hcount_in = '0; bus3.vcount_in = 12'd500; bus3.rgb_in = '0;
    bus3.hsync_in = 1'b0; bus3.vsync_in = 1'b0; bus3.hblnk_in = 1'b0; bus3.vblnk_in = 1'b0;
    bus3.game_on = 1'b0; bus3.play_selected = 1'b0; bus3.menu_on = 1'b0;
    test_reset();
    test_passthrough();
    test_basic_hit();
    test_tick();
    test_respawn();
    test_menu_exit();
    test_random();
    test_frames_per_move();
`ifdef OBSTACLE_SPEEDUP_EN
    test_speedup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
